// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the TSC multi-cycle controller:
// opcodes, function codes, FSM states, datapath select values.
package multicycle_control_pkg;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  localparam logic [1:0] SRC_B_RT   = 2'd0;
  localparam logic [1:0] SRC_B_ONE  = 2'd1;
  localparam logic [1:0] SRC_B_SEXT = 2'd2;
  localparam logic [1:0] SRC_B_ZEXT = 2'd3;

  localparam logic [1:0] REG_DST_RT   = 2'd0;
  localparam logic [1:0] REG_DST_RD   = 2'd1;
  localparam logic [1:0] REG_DST_LINK = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;
  localparam logic [1:0] M2R_LHI = 2'd3;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef struct packed {
    logic is_valid;
    logic is_rtype;
    logic is_branch;
    logic is_jump;
    logic is_jreg;
    logic is_link;
    logic is_load;
    logic is_store;
    logic is_wwd;
    logic is_hlt;
    logic is_adi;
    logic is_ori;
    logic is_lhi;
  } inst_cls_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// Instruction class decoder: opcode/func_code to one-hot
// class flags; undefined encodings leave is_valid low.
module control_decode
  import multicycle_control_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [5:0] func_code,
  output inst_cls_t  cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_BNE, OP_BEQ,
      OP_BGZ, OP_BLZ: cls.is_branch = 1'b1;
      OP_ADI:         cls.is_adi    = 1'b1;
      OP_ORI:         cls.is_ori    = 1'b1;
      OP_LHI:         cls.is_lhi    = 1'b1;
      OP_LWD:         cls.is_load   = 1'b1;
      OP_SWD:         cls.is_store  = 1'b1;
      OP_JMP:         cls.is_jump   = 1'b1;
      OP_JAL: begin
        cls.is_jump = 1'b1;
        cls.is_link = 1'b1;
      end
      OP_RTYPE: begin
        case (func_code)
          FN_JPR: begin
            cls.is_jump = 1'b1;
            cls.is_jreg = 1'b1;
          end
          FN_JRL: begin
            cls.is_jump = 1'b1;
            cls.is_jreg = 1'b1;
            cls.is_link = 1'b1;
          end
          FN_WWD: cls.is_wwd = 1'b1;
          FN_HLT: cls.is_hlt = 1'b1;
          default:
            cls.is_rtype = (func_code >= FN_ADD)
                         && (func_code <= FN_SHR);
        endcase
      end
      default: ;
    endcase
    cls.is_valid = cls.is_rtype | cls.is_branch
                 | cls.is_jump  | cls.is_load
                 | cls.is_store | cls.is_wwd
                 | cls.is_hlt   | cls.is_adi
                 | cls.is_ori   | cls.is_lhi;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle IF/ID/EX/MEM/WB controller for the 16-bit TSC core
// with memory handshake and retired-instruction counter.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int WORD  = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       opcode,
  input  logic [5:0]       func_code,
  input  logic             mem_ack,
  input  logic             br_cond,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_mode,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             wwd_valid,
  output logic             is_halted,
  output logic [CNT_W-1:0] num_inst
);

  if (WORD < 16) begin : g_word_chk
    $error("multicycle_control: WORD must be >= 16");
  end

  state_t    state;
  state_t    state_nxt;
  inst_cls_t cls;
  logic      retire;

  control_decode u_decode (
    .opcode    (opcode),
    .func_code (func_code),
    .cls       (cls)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IF;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_inst <= '0;
    end else if (retire) begin
      num_inst <= num_inst + 1'b1;
    end
  end

  // Outputs are gated by reset_n so a pending request drops at once.
  always_comb begin
    state_nxt  = state;
    retire     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    alu_mode   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_RT;
    reg_write  = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = M2R_ALU;
    wwd_valid  = 1'b0;
    is_halted  = 1'b0;
    if (reset_n) begin
      unique case (state)
        S_IF: begin
          mem_read  = 1'b1;
          alu_src_b = SRC_B_ONE;
          if (mem_ack) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            state_nxt = S_ID;
          end
        end
        S_ID: begin
          alu_src_b = SRC_B_SEXT;
          state_nxt = S_IF;
          retire    = 1'b1;
          if (!cls.is_valid) begin
            state_nxt = S_IF;
          end else if (cls.is_hlt) begin
            state_nxt = S_HALT;
          end else if (cls.is_jump) begin
            pc_write = 1'b1;
            pc_src   = cls.is_jreg ? PC_SRC_RS
                                   : PC_SRC_JUMP;
            if (cls.is_link) begin
              reg_write  = 1'b1;
              reg_dst    = REG_DST_LINK;
              mem_to_reg = M2R_PC;
            end
          end else if (cls.is_wwd) begin
            wwd_valid = 1'b1;
          end else begin
            retire    = 1'b0;
            state_nxt = S_EX;
          end
        end
        S_EX: begin
          alu_mode  = 1'b1;
          alu_src_a = 1'b1;
          state_nxt = S_WB;
          unique case (1'b1)
            cls.is_branch: begin
              alu_src_b = SRC_B_RT;
              pc_write  = br_cond;
              pc_src    = PC_SRC_ALUOUT;
              state_nxt = S_IF;
              retire    = 1'b1;
            end
            cls.is_load, cls.is_store: begin
              alu_mode  = 1'b0;
              alu_src_b = SRC_B_SEXT;
              state_nxt = S_MEM;
            end
            cls.is_adi: alu_src_b = SRC_B_SEXT;
            cls.is_ori: alu_src_b = SRC_B_ZEXT;
            default:    alu_src_b = SRC_B_RT;
          endcase
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = cls.is_load;
          mem_write = !cls.is_load;
          if (mem_ack) begin
            if (cls.is_load) begin
              state_nxt = S_WB;
            end else begin
              state_nxt = S_IF;
              retire    = 1'b1;
            end
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          reg_dst   = cls.is_rtype ? REG_DST_RD
                                   : REG_DST_RT;
          if (cls.is_load) begin
            mem_to_reg = M2R_MDR;
          end else if (cls.is_lhi) begin
            mem_to_reg = M2R_LHI;
          end
          state_nxt = S_IF;
          retire    = 1'b1;
        end
        S_HALT: is_halted = 1'b1;
        default: state_nxt = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; a second instance
// with a 2-bit counter shares all inputs to exercise wrap.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  opcode;
  logic [5:0]  func_code;
  logic        mem_ack;
  logic        br_cond;
  logic        mem_read;
  logic        mem_write;
  logic        i_or_d;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        alu_mode;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic        wwd_valid;
  logic        is_halted;
  logic [15:0] num_inst;

  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_i_or_d;
  logic        w_ir_write;
  logic        w_pc_write;
  logic [1:0]  w_pc_src;
  logic        w_alu_mode;
  logic        w_alu_src_a;
  logic [1:0]  w_alu_src_b;
  logic        w_reg_write;
  logic [1:0]  w_reg_dst;
  logic [1:0]  w_mem_to_reg;
  logic        w_wwd_valid;
  logic        w_is_halted;
  logic [1:0]  w_num_inst;

  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  multicycle_control #(.WORD(16), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .opcode(opcode), .func_code(func_code),
    .mem_ack(mem_ack), .br_cond(br_cond),
    .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src),
    .alu_mode(alu_mode), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .wwd_valid(wwd_valid), .is_halted(is_halted),
    .num_inst(num_inst)
  );

  multicycle_control #(.WORD(16), .CNT_W(2)) dut_w (
    .clk(clk), .reset_n(reset_n),
    .opcode(opcode), .func_code(func_code),
    .mem_ack(mem_ack), .br_cond(br_cond),
    .mem_read(w_mem_read), .mem_write(w_mem_write),
    .i_or_d(w_i_or_d), .ir_write(w_ir_write),
    .pc_write(w_pc_write), .pc_src(w_pc_src),
    .alu_mode(w_alu_mode), .alu_src_a(w_alu_src_a),
    .alu_src_b(w_alu_src_b), .reg_write(w_reg_write),
    .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg),
    .wwd_valid(w_wwd_valid), .is_halted(w_is_halted),
    .num_inst(w_num_inst)
  );

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs IF with 'waits' idle cycles, leaves bench in ID.
  task automatic fetch(input logic [3:0] op,
                       input logic [5:0] fn,
                       input int waits);
    opcode = op;
    func_code = fn;
    for (int i = 0; i < waits; i++) begin
      mem_ack = 1'b0;
      #1;
      check("if_rd", mem_read, 1);
      check("if_irw", ir_write, 0);
      cyc();
    end
    mem_ack = 1'b1;
    #1;
    check("if_irw_ack", ir_write, 1);
    check("if_pcw_ack", pc_write, 1);
    check("if_pcsrc", pc_src, 0);
    check("if_iod", i_or_d, 0);
    check("if_srcb", alu_src_b, 1);
    cyc();
    mem_ack = 1'b0;
    #1;
    check("id_srcb", alu_src_b, 2);
    check("id_mode", alu_mode, 0);
  endtask

  task automatic retired();
    exp_cnt++;
    check("num_inst", num_inst, 16'(exp_cnt));
    check("num_wrap", w_num_inst, 16'(exp_cnt % 4));
    check("back_if", mem_read, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    opcode = 4'd0;
    func_code = 6'd0;
    mem_ack = 1'b0;
    br_cond = 1'b0;
    #2;
    check("rst_rd", mem_read, 0);
    check("rst_cnt", num_inst, 0);
    check("rst_halt", is_halted, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // ADI: IF held three cycles
    fetch(4'd4, 6'd0, 2);
    check("id_pcw", pc_write, 0);
    cyc();
    check("ex_mode", alu_mode, 1);
    check("ex_srcb", alu_src_b, 2);
    check("ex_srca", alu_src_a, 1);
    cyc();
    check("wb_rw", reg_write, 1);
    check("wb_dst", reg_dst, 0);
    check("wb_m2r", mem_to_reg, 0);
    cyc();
    retired();

    // LWD with delayed acks
    fetch(4'd7, 6'd0, 2);
    cyc();
    check("lwd_ex_mode", alu_mode, 0);
    check("lwd_ex_srcb", alu_src_b, 2);
    cyc();
    for (int i = 0; i < 2; i++) begin
      #1;
      check("lwd_mem_rd", mem_read, 1);
      check("lwd_mem_iod", i_or_d, 1);
      check("lwd_mem_wr", mem_write, 0);
      cyc();
    end
    mem_ack = 1'b1;
    #1;
    check("lwd_ack_rd", mem_read, 1);
    check("lwd_ack_irw", ir_write, 0);
    cyc();
    mem_ack = 1'b0;
    #1;
    check("lwd_wb_m2r", mem_to_reg, 1);
    check("lwd_wb_rw", reg_write, 1);
    cyc();
    retired();

    // SWD
    fetch(4'd8, 6'd0, 0);
    cyc();
    cyc();
    check("swd_mem_wr", mem_write, 1);
    check("swd_mem_rd", mem_read, 0);
    check("swd_mem_iod", i_or_d, 1);
    check("swd_mem_rw", reg_write, 0);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    #1;
    retired();

    // BEQ taken / not taken
    fetch(4'd1, 6'd0, 0);
    cyc();
    br_cond = 1'b1;
    #1;
    check("beq_t_pcw", pc_write, 1);
    check("beq_t_src", pc_src, 1);
    check("beq_t_srcb", alu_src_b, 0);
    check("beq_t_srca", alu_src_a, 1);
    cyc();
    retired();
    fetch(4'd1, 6'd0, 1);
    cyc();
    br_cond = 1'b0;
    #1;
    check("beq_n_pcw", pc_write, 0);
    cyc();
    retired();

    // JAL, JRL, WWD
    fetch(4'd10, 6'd0, 0);
    check("jal_pcw", pc_write, 1);
    check("jal_src", pc_src, 2);
    check("jal_rw", reg_write, 1);
    check("jal_dst", reg_dst, 2);
    check("jal_m2r", mem_to_reg, 2);
    cyc();
    retired();
    fetch(4'd15, 6'd26, 0);
    check("jrl_src", pc_src, 3);
    check("jrl_rw", reg_write, 1);
    cyc();
    retired();
    fetch(4'd15, 6'd28, 0);
    check("wwd_v", wwd_valid, 1);
    cyc();
    check("wwd_v_off", wwd_valid, 0);
    retired();

    // undefined opcode and undefined func retire as NOP
    fetch(4'd12, 6'd0, 0);
    check("nop_pcw", pc_write, 0);
    check("nop_rw", reg_write, 0);
    cyc();
    retired();
    fetch(4'd15, 6'd10, 0);
    check("nop_fn_rw", reg_write, 0);
    cyc();
    retired();

    // reset in the middle of a LWD memory wait
    fetch(4'd7, 6'd0, 0);
    cyc();
    cyc();
    check("mid_mem_rd", mem_read, 1);
    reset_n = 1'b0;
    #1;
    check("rst_mem_rd", mem_read, 0);
    check("rst_mem_iod", i_or_d, 0);
    check("rst_mem_cnt", num_inst, 0);
    exp_cnt = 0;
    cyc();
    reset_n = 1'b1;
    #1;
    check("rst_if_rd", mem_read, 1);

    // HLT then stray acks
    fetch(4'd15, 6'd29, 0);
    check("hlt_id_halt", is_halted, 0);
    cyc();
    exp_cnt++;
    check("hlt_halt", is_halted, 1);
    check("hlt_cnt", num_inst, 16'(exp_cnt));
    check("hlt_rd", mem_read, 0);
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("halt_rd", mem_read, 0);
      check("halt_irw", ir_write, 0);
      check("halt_sticky", is_halted, 1);
      check("halt_cnt", num_inst, 16'(exp_cnt));
    end
    mem_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
